filter2d_rtk: RTL and testbench
===============================

Name: filter2d_rtk

Overview:
- Next-generation streaming 2D FIR filter: single clock domain, self-contained, for raster video.
- Internal line buffers, NxN window, signed MAC pipeline, rounding and saturation in one block.
- Adds a runtime-loadable, double-buffered signed kernel that is swapped only at frame boundaries.
- Emits only fully-interior ("valid") window positions, plus an end-of-frame pulse and a saturation flag.

Parameters:
- FRAME_H, 1080, active rows per frame.
- FRAME_W, 1920, active pixels per row.
- WIN_SIZE, 3, window side N (odd, 3..7).
- DIN_WIDTH, 8, unsigned pixel width.
- COEF_WIDTH, 9, signed two's-complement coefficient width.
- DOUT_WIDTH, 10, unsigned output width.
- FOUT_SHIFT, 6, result right-shift (0..16).

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- frame_start  in  1  single-cycle frame sync.
- din_vld  in  1  pixel strobe.
- din  in  DIN_WIDTH  pixel, raster order.
- coef_wr  in  1  shadow-kernel write strobe.
- coef_addr  in  ceil(log2(N*N))  tap index, row*N+col, row 0 = oldest line.
- coef_data  in  COEF_WIDTH  signed coefficient.
- kernel_commit  in  1  request shadow->active swap at next frame_start.
- kernel_pending  out  1  commit requested, not yet applied.
- dout_vld  out  1  output strobe.
- dout  out  DOUT_WIDTH  filtered pixel.
- dout_sat  out  1  qualifies dout: result was clipped.
- frame_done  out  1  pulse with the last dout_vld of a frame.

Behaviour:
- Reset: all outputs 0. Row/col counters 0. Pipeline valids cleared. Line buffers need not be cleared.
- Reset, kernel banks: active and shadow = centre tap 2^FOUT_SHIFT, all others 0 (identity).
- Reset mid-frame: aborts in-flight results; no dout_vld or frame_done for them. Next din_vld is treated as pixel (0,0).
- frame_start: zeroes row/col. If coincident with din_vld, that pixel is (0,0); otherwise the next valid pixel is (0,0).
- Counters: advance only on din_vld; col wraps at FRAME_W-1 and increments row.
- Counters after the last row: pixels beyond row FRAME_H-1 are ignored (no output) until frame_start.
- din_vld gaps: allowed anywhere; the pipeline advances every cycle regardless.
- Window: formed on each din_vld. Taps are the last N pixels of the current row plus the same columns from the previous N-1 rows (N-1 line buffers, depth FRAME_W).
- Window valid: only when row >= N-1 and col >= N-1. Output count per frame = (FRAME_H-N+1)*(FRAME_W-N+1).
- Pipeline latency = 4 cycles from the qualifying din_vld to dout_vld:
  - S1: window register.
  - S2: N*N signed products, pixel zero-extended.
  - S3: adder-tree sum, full precision, DIN_WIDTH+COEF_WIDTH+ceil(log2(N*N)) bits.
  - S4: rounding, shift, saturation.
- Arithmetic:
  - Rounding: if FOUT_SHIFT>0, r = (sum + 2^(FOUT_SHIFT-1)) >>> FOUT_SHIFT, arithmetic shift (round half up). Otherwise r = sum.
  - Saturation: r<0 gives dout=0, dout_sat=1. r>2^DOUT_WIDTH-1 gives dout=all ones, dout_sat=1. Otherwise dout=r, dout_sat=0.
  - dout and dout_sat hold their value when dout_vld=0.
- frame_done: asserted with dout_vld for output position (FRAME_H-1, FRAME_W-1).
- Kernel, writes: coef_wr writes the shadow bank only; coef_addr >= N*N is ignored.
- Kernel, commit: kernel_commit sets kernel_pending. The next frame_start copies shadow->active and clears pending.
- Kernel, commit coincident with frame_start: applied immediately; pending stays 0.
- Kernel, write coincident with swap: the copy uses shadow contents before that cycle's write; the write is still stored in shadow.
- Kernel, timing of swap: active kernel changes only on the frame_start cycle, so every output of a frame uses one kernel. Results still in S2..S4 from the previous frame keep their products.
- Kernel, coefficient latch: coefficients are latched into S2 with the window.

Test Plan:
- Identity passthrough: FRAME_W=5, FRAME_H=4, N=3, reset kernel, din=0..19 contiguous -> exactly 6 dout_vld. dout=6,7,8,11,12,13. Each output 4 cycles after din 12,13,14,17,18,19. frame_done only with 13. dout_sat=0.
- Positive saturation: all 9 coefs=1, FOUT_SHIFT=0, DOUT_WIDTH=10, din=200 constant -> sum 1800. dout=1023, dout_sat=1 on every output.
- Negative saturation: shadow centre=-1, others 0, commit, new frame, din=50 -> dout=0, dout_sat=1.
- Rounding: FOUT_SHIFT=6, all coefs=8. din=4 constant -> 288, +32, >>6 -> dout=5. din=1 -> dout=1 (72+32=104>>6).
- Kernel swap: write new kernel and pulse kernel_commit mid-frame 0 -> frame 0 outputs unchanged and kernel_pending=1 until frame_start. Frame 1 outputs use new kernel. Also hit the case of commit and write in the same cycle as frame_start.
- Robustness:
  - Random din_vld gaps (50% duty) -> same dout sequence as the contiguous run.
  - rst_n low mid-row 2 -> outputs 0 immediately, no stale dout_vld. Next frame is fully correct.

Source files
------------

// File: rtl/filter2d_rtk_if.sv
// Pixel/kernel/result bundle of the streaming 2D FIR filter.
// The filter core connects through the slave modport; the video source and sink use master.
interface filter2d_rtk_if #(
    parameter int WIN_SIZE   = 3,
    parameter int DIN_WIDTH  = 8,
    parameter int COEF_WIDTH = 9,
    parameter int DOUT_WIDTH = 10
);
    localparam int AW = $clog2(WIN_SIZE * WIN_SIZE);

    logic                         frame_start;
    logic                         din_vld;
    logic [DIN_WIDTH-1:0]         din;
    logic                         coef_wr;
    logic [AW-1:0]                coef_addr;
    logic signed [COEF_WIDTH-1:0] coef_data;
    logic                         kernel_commit;
    logic                         kernel_pending;
    logic                         dout_vld;
    logic [DOUT_WIDTH-1:0]        dout;
    logic                         dout_sat;
    logic                         frame_done;

    modport master (
        output frame_start, din_vld, din, coef_wr, coef_addr, coef_data, kernel_commit,
        input  kernel_pending, dout_vld, dout, dout_sat, frame_done
    );

    modport slave (
        input  frame_start, din_vld, din, coef_wr, coef_addr, coef_data, kernel_commit,
        output kernel_pending, dout_vld, dout, dout_sat, frame_done
    );
endinterface

// File: rtl/filter2d_rtk.sv
// Streaming NxN 2D FIR over raster video: line buffers, window, signed MAC pipeline,
// round/shift/saturate, and a double-buffered kernel swapped only on frame_start.
module filter2d_rtk #(
    parameter int FRAME_H    = 1080,
    parameter int FRAME_W    = 1920,
    parameter int WIN_SIZE   = 3,
    parameter int DIN_WIDTH  = 8,
    parameter int COEF_WIDTH = 9,
    parameter int DOUT_WIDTH = 10,
    parameter int FOUT_SHIFT = 6
) (
    input  logic          clock,
    input  logic          rst_n,
    filter2d_rtk_if.slave bus
);
    localparam int N   = WIN_SIZE;
    localparam int NT  = N * N;
    localparam int AW  = $clog2(NT);
    localparam int RW  = $clog2(FRAME_H + 1);
    localparam int CW  = $clog2(FRAME_W + 1);
    localparam int PW  = DIN_WIDTH + COEF_WIDTH;
    localparam int SW  = PW + $clog2(NT);
    localparam int EW  = SW + 1;
    localparam int CTR = NT / 2;

    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(FRAME_H);
    localparam logic [RW-1:0] ROW_WIN  = RW'(N - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(N - 1);
    localparam logic [AW:0]   NT_L     = (AW + 1)'(NT);

    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1 << FOUT_SHIFT);
    localparam logic signed [EW-1:0]         RND      = EW'((1 << FOUT_SHIFT) >> 1);
    localparam logic signed [EW-1:0]         OMAX     = EW'((1 << DOUT_WIDTH) - 1);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_accept;
    logic          w_win_ok;
    logic          w_last;
    logic          w_coef_ok;

    logic [DIN_WIDTH-1:0] r_lb [0:N-2][0:FRAME_W-1];
    logic [DIN_WIDTH-1:0] w_col_px [N];
    logic [DIN_WIDTH-1:0] r_win [NT];

    logic signed [COEF_WIDTH-1:0] r_shadow [NT];
    logic signed [COEF_WIDTH-1:0] r_active [NT];
    logic                         r_pending;

    logic signed [PW-1:0] w_prod [NT];
    logic signed [PW-1:0] r_prod [NT];
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] r_sum;
    logic signed [EW-1:0] w_rnd;
    logic [DOUT_WIDTH-1:0] w_dout;
    logic                  w_sat;

    logic r_vld1, r_last1, r_vld2, r_last2, r_vld3, r_last3;
    logic                  r_dout_vld;
    logic [DOUT_WIDTH-1:0] r_dout;
    logic                  r_dout_sat;
    logic                  r_frame_done;

    // Position of the pixel on the bus this cycle; frame_start forces it to (0,0).
    always_comb begin
        w_row     = bus.frame_start ? '0 : r_row;
        w_col     = bus.frame_start ? '0 : r_col;
        w_accept  = bus.din_vld && (w_row < ROW_END);
        w_win_ok  = (w_row >= ROW_WIN) && (w_col >= COL_WIN);
        w_last    = (w_row == ROW_LAST) && (w_col == COL_LAST);
        w_coef_ok = ({1'b0, bus.coef_addr} < NT_L);
    end

    // Raster counters; row parks at FRAME_H so surplus pixels are dropped until frame_start.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end else if (bus.frame_start) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_row <= r_row;
            r_col <= r_col;
        end
    end

    // New window column: current pixel at the bottom, older lines above it.
    always_comb begin
        w_col_px[N-1] = bus.din;
        for (int k = 0; k < N - 1; k++) begin
            w_col_px[N-2-k] = r_lb[k][w_col];
        end
    end

    // Line buffers cascade per column; window (S1) shifts left with the new column at N-1.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_lb[0][w_col] <= bus.din;
            for (int k = 1; k < N - 1; k++) begin
                r_lb[k][w_col] <= r_lb[k-1][w_col];
            end
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    r_win[r*N+c] <= r_win[r*N+c+1];
                end
                r_win[r*N+N-1] <= w_col_px[r];
            end
        end
    end

    // Kernel banks; the swap copies shadow before any same-cycle write lands.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
                r_shadow[i] <= (i == CTR) ? COEF_ONE : '0;
                r_active[i] <= (i == CTR) ? COEF_ONE : '0;
            end
            r_pending <= 1'b0;
        end else begin
            if (bus.coef_wr && w_coef_ok) begin
                r_shadow[bus.coef_addr] <= bus.coef_data;
            end
            if (bus.frame_start && (r_pending || bus.kernel_commit)) begin
                for (int i = 0; i < NT; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            r_pending <= bus.frame_start ? 1'b0 : (r_pending | bus.kernel_commit);
        end
    end

    // Valid/last tags travelling alongside the data stages.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1  <= 1'b0;
            r_last1 <= 1'b0;
            r_vld2  <= 1'b0;
            r_last2 <= 1'b0;
            r_vld3  <= 1'b0;
            r_last3 <= 1'b0;
        end else begin
            r_vld1  <= w_accept && w_win_ok;
            r_last1 <= w_last;
            r_vld2  <= r_vld1;
            r_last2 <= r_last1;
            r_vld3  <= r_vld2;
            r_last3 <= r_last2;
        end
    end

    // Signed products, pixels zero-extended; active kernel sampled together with the window.
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            w_prod[i] = PW'($signed({1'b0, r_win[i]})) * PW'(r_active[i]);
        end
    end

    // Full-precision accumulation of all taps.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NT; i++) begin
            w_sum = w_sum + SW'(r_prod[i]);
        end
    end

    // S2 products and S3 sum registers.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NT; i++) begin
            r_prod[i] <= w_prod[i];
        end
        r_sum <= w_sum;
    end

    // Round half up, arithmetic shift, clip into the unsigned output range.
    always_comb begin
        w_rnd  = (EW'(r_sum) + RND) >>> FOUT_SHIFT;
        w_dout = '0;
        w_sat  = 1'b0;
        if (w_rnd[EW-1]) begin
            w_dout = '0;
            w_sat  = 1'b1;
        end else if (w_rnd > OMAX) begin
            w_dout = '1;
            w_sat  = 1'b1;
        end else begin
            w_dout = w_rnd[DOUT_WIDTH-1:0];
            w_sat  = 1'b0;
        end
    end

    // S4 output register; data and flag hold between strobes.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_vld   <= 1'b0;
            r_dout       <= '0;
            r_dout_sat   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dout_vld   <= r_vld3;
            r_frame_done <= r_vld3 & r_last3;
            if (r_vld3) begin
                r_dout     <= w_dout;
                r_dout_sat <= w_sat;
            end else begin
                r_dout     <= r_dout;
                r_dout_sat <= r_dout_sat;
            end
        end
    end

    assign bus.kernel_pending = r_pending;
    assign bus.dout_vld       = r_dout_vld;
    assign bus.dout           = r_dout;
    assign bus.dout_sat       = r_dout_sat;
    assign bus.frame_done     = r_frame_done;
endmodule

// File: tb/tb_filter2d_rtk.sv
// Scoreboard bench for filter2d_rtk on a 5x4 frame, 3x3 window: two instances with
// FOUT_SHIFT 6 and 0 share one stimulus stream; a convolution model predicts both.
module tb_filter2d_rtk;
    localparam int H  = 4;
    localparam int W  = 5;
    localparam int N  = 3;
    localparam int NT = 9;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    filter2d_rtk_if #(.WIN_SIZE(N), .DIN_WIDTH(8), .COEF_WIDTH(9), .DOUT_WIDTH(10)) bus0 ();
    filter2d_rtk_if #(.WIN_SIZE(N), .DIN_WIDTH(8), .COEF_WIDTH(9), .DOUT_WIDTH(10)) bus1 ();

    assign bus1.frame_start   = bus0.frame_start;
    assign bus1.din_vld       = bus0.din_vld;
    assign bus1.din           = bus0.din;
    assign bus1.coef_wr       = bus0.coef_wr;
    assign bus1.coef_addr     = bus0.coef_addr;
    assign bus1.coef_data     = bus0.coef_data;
    assign bus1.kernel_commit = bus0.kernel_commit;

    filter2d_rtk #(.FRAME_H(H), .FRAME_W(W), .WIN_SIZE(N), .DIN_WIDTH(8), .COEF_WIDTH(9),
                   .DOUT_WIDTH(10), .FOUT_SHIFT(6)) u0 (.clock(clock), .rst_n(rst_n), .bus(bus0));
    filter2d_rtk #(.FRAME_H(H), .FRAME_W(W), .WIN_SIZE(N), .DIN_WIDTH(8), .COEF_WIDTH(9),
                   .DOUT_WIDTH(10), .FOUT_SHIFT(0)) u1 (.clock(clock), .rst_n(rst_n), .bus(bus1));

    always #5 clock = ~clock;

    int ec = 0;
    always @(posedge clock) ec <= ec + 1;

    typedef struct { int s0; int s1; bit last; int due; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int m_row, m_col;
    bit m_pend;
    int m_sh [2][NT];
    int m_ac [2][NT];
    int m_pix [H][W];
    int src [H*W];
    int hk [NT];
    int log0[$], log1[$];
    bit slog0[$], slog1[$];
    int ref0[$], ref1[$];
    int out_cnt, fd_cnt;
    int last0;
    bit lsat0;

    function automatic int sat_val(input int s, input int sh, output bit sat);
        int r;
        r = (s + ((1 << sh) >> 1)) >>> sh;
        if (r < 0) begin sat = 1'b1; return 0; end
        if (r > 1023) begin sat = 1'b1; return 1023; end
        sat = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_row = 0; m_col = 0; m_pend = 1'b0;
        for (int i = 0; i < NT; i++) begin
            m_sh[0][i] = (i == 4) ? 64 : 0;
            m_ac[0][i] = (i == 4) ? 64 : 0;
            m_sh[1][i] = (i == 4) ? 1 : 0;
            m_ac[1][i] = (i == 4) ? 1 : 0;
        end
        last0 = 0; lsat0 = 1'b0;
    endtask

    // One bus cycle; the model is advanced as the DUT will see it on the coming edge.
    task automatic drive(input bit fs, input bit vld, input int d, input bit cwr = 1'b0,
                         input int ca = 0, input int cd = 0, input bit cm = 1'b0);
        int s0, s1;
        @(posedge clock); #1;
        bus0.frame_start = fs; bus0.din_vld = vld; bus0.din = 8'(d);
        bus0.coef_wr = cwr; bus0.coef_addr = 4'(ca); bus0.coef_data = 9'(cd);
        bus0.kernel_commit = cm;
        if (fs) begin m_row = 0; m_col = 0; end
        for (int u = 0; u < 2; u++) begin
            if (fs && (m_pend || cm)) for (int i = 0; i < NT; i++) m_ac[u][i] = m_sh[u][i];
            if (cwr && ca < NT) m_sh[u][ca] = cd;
        end
        m_pend = fs ? 1'b0 : (m_pend | cm);
        if (vld && m_row < H) begin
            m_pix[m_row][m_col] = d;
            if (m_row >= N - 1 && m_col >= N - 1) begin
                s0 = 0; s1 = 0;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        s0 += m_pix[m_row-2+r][m_col-2+c] * m_ac[0][r*N+c];
                        s1 += m_pix[m_row-2+r][m_col-2+c] * m_ac[1][r*N+c];
                    end
                end
                sb.push_back('{s0, s1, (m_row == H - 1 && m_col == W - 1), ec + 4});
            end
            if (m_col == W - 1) begin m_col = 0; m_row++; end
            else m_col++;
        end
    endtask

    task automatic load_kernel(input bit commit);
        for (int k = 0; k < NT; k++) drive(1'b0, 1'b0, 0, 1'b1, k, hk[k]);
        if (commit) drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    // fsmode: 0 separate frame_start, 1 frame_start with pixel 0, 2 none.
    task automatic run_frame(input int fsmode, input int gap, input int hook,
                             input bit fs_cwr = 1'b0, input int fs_ca = 0,
                             input int fs_cd = 0, input bit fs_cm = 1'b0);
        bit first;
        log0.delete(); log1.delete(); slog0.delete(); slog1.delete();
        out_cnt = 0; fd_cnt = 0;
        if (fsmode == 0) drive(1'b1, 1'b0, 0, fs_cwr, fs_ca, fs_cd, fs_cm);
        for (int i = 0; i < H * W; i++) begin
            while (gap > 0 && $urandom_range(99) < gap) drive(1'b0, 1'b0, $urandom_range(255));
            if (i == hook) load_kernel(1'b0);
            first = (fsmode == 1) && (i == 0);
            drive(first, 1'b1, src[i], first & fs_cwr, fs_ca, fs_cd, (i == hook) || (first & fs_cm));
        end
        for (int k = 0; k < 20 && sb.size() > 0; k++) drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL drain_timeout pending_outputs=%0d required=0", sb.size());
        end
    endtask

    // Output monitor: every strobe must match the head of the scoreboard at the right cycle.
    always @(negedge clock) begin
        exp_t e;
        int x0, x1;
        bit b0, b1;
        if (rst_n) begin
            if (bus0.dout_vld || bus1.dout_vld) begin
                checks++;
                if (bus1.dout_vld !== bus0.dout_vld) begin
                    errors++; $display("FAIL vld_pair u0=%0b u1=%0b required equal", bus0.dout_vld, bus1.dout_vld);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL unexpected_vld dout=%0d required no output", bus0.dout);
                end else begin
                    e = sb.pop_front();
                    x0 = sat_val(e.s0, 6, b0);
                    x1 = sat_val(e.s1, 0, b1);
                    checks++;
                    if (ec !== e.due) begin
                        errors++; $display("FAIL latency cycle=%0d required=%0d", ec, e.due);
                    end
                    checks++;
                    if (bus0.dout !== 10'(x0) || bus0.dout_sat !== b0) begin
                        errors++; $display("FAIL u0_dout got=%0d/%0b required=%0d/%0b", bus0.dout, bus0.dout_sat, x0, b0);
                    end
                    checks++;
                    if (bus1.dout !== 10'(x1) || bus1.dout_sat !== b1) begin
                        errors++; $display("FAIL u1_dout got=%0d/%0b required=%0d/%0b", bus1.dout, bus1.dout_sat, x1, b1);
                    end
                    checks++;
                    if (bus0.frame_done !== e.last || bus1.frame_done !== e.last) begin
                        errors++; $display("FAIL frame_done got=%0b/%0b required=%0b", bus0.frame_done, bus1.frame_done, e.last);
                    end
                end
                log0.push_back(int'(bus0.dout)); slog0.push_back(bus0.dout_sat);
                log1.push_back(int'(bus1.dout)); slog1.push_back(bus1.dout_sat);
                out_cnt++;
                if (bus0.frame_done) fd_cnt++;
            end else begin
                checks++;
                if (bus0.frame_done !== 1'b0 || bus0.dout !== 10'(last0) || bus0.dout_sat !== lsat0) begin
                    errors++; $display("FAIL idle_hold done=%0b dout=%0d sat=%0b required 0/%0d/%0b",
                                       bus0.frame_done, bus0.dout, bus0.dout_sat, last0, lsat0);
                end
            end
            last0 = int'(bus0.dout); lsat0 = bus0.dout_sat;
        end
    end

    task automatic check_counts(input string name);
        checks++;
        if (out_cnt != 6 || fd_cnt != 1) begin
            errors++; $display("FAIL %s_counts outputs=%0d done=%0d required 6/1", name, out_cnt, fd_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #1;
        checks++;
        if (bus0.dout_vld !== 1'b0 || bus0.dout !== 10'd0 || bus0.dout_sat !== 1'b0 ||
            bus0.frame_done !== 1'b0 || bus0.kernel_pending !== 1'b0 || bus1.dout_vld !== 1'b0) begin
            errors++; $display("FAIL reset_outputs vld=%0b dout=%0d sat=%0b done=%0b pend=%0b required all 0",
                               bus0.dout_vld, bus0.dout, bus0.dout_sat, bus0.frame_done, bus0.kernel_pending);
        end
        model_reset();
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_identity();
        int exp_id[6] = '{6, 7, 8, 11, 12, 13};
        for (int i = 0; i < H * W; i++) src[i] = i;
        run_frame(0, 0, -1);
        check_counts("identity");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= log0.size() || log0[i] != exp_id[i] || slog0[i] != 1'b0 || log1[i] != exp_id[i]) begin
                errors++; $display("FAIL identity_%0d got=%0d required=%0d", i, (i < log0.size()) ? log0[i] : -1, exp_id[i]);
            end
        end
        // Pixels past the last row are dropped without frame_start.
        out_cnt = 0;
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 99);
        repeat (6) drive(1'b0, 1'b0, 0);
        checks++;
        if (out_cnt != 0) begin
            errors++; $display("FAIL overrun_outputs got=%0d required=0", out_cnt);
        end
    endtask

    task automatic test_pos_sat();
        for (int k = 0; k < NT; k++) hk[k] = 1;
        load_kernel(1'b1);
        for (int i = 0; i < H * W; i++) src[i] = 200;
        run_frame(0, 0, -1);
        check_counts("pos_sat");
        for (int i = 0; i < log1.size(); i++) begin
            checks++;
            if (log1[i] != 1023 || slog1[i] != 1'b1 || log0[i] != 28) begin
                errors++; $display("FAIL pos_sat_%0d got=%0d/%0b u0=%0d required=1023/1 u0=28", i, log1[i], slog1[i], log0[i]);
            end
        end
    endtask

    task automatic test_neg_sat();
        for (int k = 0; k < NT; k++) hk[k] = (k == 4) ? -1 : 0;
        load_kernel(1'b1);
        for (int i = 0; i < H * W; i++) src[i] = 50;
        run_frame(0, 0, -1);
        check_counts("neg_sat");
        for (int i = 0; i < log0.size(); i++) begin
            checks++;
            if (log0[i] != 0 || slog0[i] != 1'b1 || log1[i] != 0 || slog1[i] != 1'b1) begin
                errors++; $display("FAIL neg_sat_%0d got=%0d/%0b required=0/1", i, log0[i], slog0[i]);
            end
        end
    endtask

    task automatic test_rounding();
        int din_v[2] = '{4, 1};
        int exp_v[2] = '{5, 1};
        for (int k = 0; k < NT; k++) hk[k] = 8;
        load_kernel(1'b1);
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < H * W; i++) src[i] = din_v[t];
            run_frame(0, 0, -1);
            checks++;
            if (log0.size() != 6 || log0[0] != exp_v[t] || log0[5] != exp_v[t] || slog0[0] != 1'b0) begin
                errors++; $display("FAIL rounding_din%0d got=%0d required=%0d", din_v[t], log0[0], exp_v[t]);
            end
        end
    endtask

    task automatic test_kernel_swap();
        int exp_dbl[6] = '{12, 14, 16, 22, 24, 26};
        for (int i = 0; i < H * W; i++) src[i] = i;
        for (int k = 0; k < NT; k++) hk[k] = (k == 4) ? 64 : 0;
        run_frame(0, 0, 7);
        checks++;
        if (log0.size() != 6 || log0[0] != 7) begin
            errors++; $display("FAIL swap_old_kernel got=%0d required=7", log0[0]);
        end
        checks++;
        if (bus0.kernel_pending !== 1'b1) begin
            errors++; $display("FAIL swap_pending got=%0b required=1", bus0.kernel_pending);
        end
        run_frame(1, 0, -1, 1'b1, 4, 128, 1'b1);
        checks++;
        if (log0.size() != 6 || log0[0] != 6 || log0[5] != 13 || bus0.kernel_pending !== 1'b0) begin
            errors++; $display("FAIL swap_new_kernel got=%0d pend=%0b required=6/0", log0[0], bus0.kernel_pending);
        end
        run_frame(0, 0, -1);
        checks++;
        if (log0.size() != 6 || log0[0] != 6) begin
            errors++; $display("FAIL swap_no_commit got=%0d required=6", log0[0]);
        end
        drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1);
        run_frame(0, 0, -1);
        check_counts("swap");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= log0.size() || log0[i] != exp_dbl[i]) begin
                errors++; $display("FAIL swap_late_write_%0d got=%0d required=%0d", i, (i < log0.size()) ? log0[i] : -1, exp_dbl[i]);
            end
        end
        ref0 = log0; ref1 = log1;
    endtask

    task automatic test_gaps();
        run_frame(0, 50, -1);
        check_counts("gaps");
        checks++;
        if (log0 != ref0 || log1 != ref1) begin
            errors++; $display("FAIL gaps_sequence got_first=%0d required_first=%0d", log0[0], ref0[0]);
        end
    endtask

    task automatic test_reset_mid();
        int exp_id[6] = '{6, 7, 8, 11, 12, 13};
        for (int i = 0; i < H * W; i++) src[i] = i;
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 14; i++) drive(1'b0, 1'b1, src[i]);
        @(posedge clock); #1;
        bus0.din_vld = 1'b0; bus0.frame_start = 1'b0;
        rst_n = 1'b0; #1;
        checks++;
        if (bus0.dout_vld !== 1'b0 || bus0.dout !== 10'd0 || bus0.dout_sat !== 1'b0 || bus0.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_outputs vld=%0b dout=%0d required 0/0", bus0.dout_vld, bus0.dout);
        end
        model_reset();
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        run_frame(2, 0, -1);
        check_counts("reset_mid");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= log0.size() || log0[i] != exp_id[i]) begin
                errors++; $display("FAIL reset_mid_%0d got=%0d required=%0d", i, (i < log0.size()) ? log0[i] : -1, exp_id[i]);
            end
        end
    endtask

    initial begin
        bus0.frame_start = 1'b0; bus0.din_vld = 1'b0; bus0.din = 8'd0;
        bus0.coef_wr = 1'b0; bus0.coef_addr = 4'd0; bus0.coef_data = 9'd0; bus0.kernel_commit = 1'b0;
        model_reset();
        test_reset();
        test_identity();
        test_pos_sat();
        test_neg_sat();
        test_rounding();
        test_kernel_swap();
        test_gaps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required completion", $time);
        $fatal(1);
    end
endmodule
